alu_core_seq: RTL
=================

// Module: alu_core_seq
// PURPOSE
//  Parametrised, registered successor of the 4-bit enabled NAND unit. Executes one of
//  eight logic/arithmetic ops on WIDTH-bit operands, including an iterative shift-add
//  multiply. Uses valid/ready handshakes on input and output. Sits between register-file
//  read ports (Rd1/Rd2) and the write-back stage of the datapath.
// PARAMETERS
//  WIDTH   4   operand/result width in bits, >=2
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      synchronous, active-high reset
//  en         in   1      global enable; 0 = freeze all state (stall), handshakes inactive
//  in_valid   in   1      operands+op presented
//  in_ready   out  1      unit can accept this cycle
//  op         in   3      000 NAND,001 AND,010 OR,011 XOR,100 ADD,101 SUB,110 NOT Rd1,111 MUL
//  Rd1        in   WIDTH  operand A
//  Rd2        in   WIDTH  operand B
//  out_valid  out  1      result/flags valid; held until accepted
//  out_ready  in   1      downstream accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  carry      out  1      ADD carry-out; SUB borrow (Rd1<Rd2 unsigned); MUL upper half !=0; else 0
// BEHAVIOUR
//  - Reset: state IDLE, out_valid=0, result=0, zero=0, carry=0, counter=0; rst overrides en.
//  - FSM states: IDLE, MUL_BUSY, DONE.
//  - in_ready = en && (state==IDLE || (state==DONE && out_ready)); comb. path from out_ready.
//  - Accept = in_valid && in_ready. Operands and op are captured only on accept.
//  - Non-MUL op accepted in cycle N: result/flags registered, out_valid=1 in cycle N+1 (DONE).
//  - MUL accepted: -> MUL_BUSY, 2*WIDTH-bit accumulator cleared, count=0. One multiplier bit
//    per en-cycle (LSB first). After WIDTH steps -> DONE. out_valid rises WIDTH+1 cycles
//    after accept. result = product[WIDTH-1:0]; carry = |product[2W-1:W].
//  - ADD/SUB computed at WIDTH+1 bits; result = low WIDTH bits. SUB = Rd1 - Rd2 mod 2^WIDTH.
//  - DONE: result/flags stable while out_valid && !out_ready. out_valid && out_ready (with
//    en=1) completes transfer: with new accept in the same cycle -> process it (back-to-back,
//    no bubble for single-cycle ops); otherwise -> IDLE, out_valid=0.
//  - en=0: no accept, no completion, MUL counter/accumulator frozen, outputs hold value.
//  - out_valid never drops without out_ready (except rst).
//  - rst mid-MUL or in DONE: discard operation; IDLE next cycle, out_valid=0.
//  - in_valid while busy: ignored (in_ready=0); source must hold.
//  - zero is registered from the final result (including MUL low half).
// STRUCTURE
//  - Package alu_pkg: opcode localparams (OP_NAND..OP_MUL), FSM state encoding
//    (ST_IDLE, ST_MUL_BUSY, ST_DONE), OP_W=3.
//  - Sub-module seq_multiplier (WIDTH): start/busy/done, shift-add core with step counter
//    $clog2(WIDTH+1) bits. The top module holds the FSM, the logic/add ops, handshake and
//    output registers.
// TESTING (WIDTH=4 unless noted)
//  - NAND Rd1=4'b1100 Rd2=4'b1010 accepted cyc N -> cyc N+1 result=4'b0111, zero=0, carry=0.
//  - ADD 4'hF+4'h1 -> result=0, zero=1, carry=1; SUB 3-5 -> result=4'hE, carry=1.
//  - MUL 5*3 -> out_valid at N+5, result=4'hF, carry=0; MUL 7*3 -> result=4'h5, carry=1.
//  - Hold out_ready=0 3 cycles after result -> result stable, in_ready=0; then stream 4
//    back-to-back AND ops with out_ready=1 -> one result per cycle, no bubbles.
//  - en=0 for 2 cycles mid-MUL -> out_valid delayed exactly 2 cycles, product unchanged.
//  - rst asserted during MUL_BUSY -> next cycle out_valid=0, in_ready=1 (en=1), result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential ALU slice: operation codes,
//   operation-field width and the controller state encoding.
//   No ports; imported by alu_core_seq and seq_multiplier.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NAND = 3'b000;
  localparam logic [OP_W-1:0] OP_AND  = 3'b001;
  localparam logic [OP_W-1:0] OP_OR   = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b101;
  localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
  localparam logic [OP_W-1:0] OP_MUL  = 3'b111;

  // Controller states: waiting for work, iterating a multiply, holding a result
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MUL_BUSY = 2'b01,
    ST_DONE     = 2'b10
  } state_t;

  // True for the one operation that needs several cycles
  function automatic logic is_multicycle(input logic [OP_W-1:0] op);
    return (op == OP_MUL);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_core_seq_mul.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//   Iterative shift-add multiplier, one multiplier bit per enabled cycle,
//   LSB first. Produces the full 2*WIDTH-bit product after WIDTH steps.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   en           step enable; 0 freezes accumulator, operands and counter
//   start        load a and b and begin (ignored while busy)
//   a, b         multiplicand and multiplier
//   busy         a multiply is in progress
//   done         this cycle performs the final step (comb, includes en)
//   product_nxt  accumulator value after this cycle's step; on the cycle
//                done is high it is the complete product
// ---------------------------------------------------------------------------
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product_nxt
);

  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;

  // Partial product for the current multiplier bit is added to the
  // accumulator; exposing the sum lets the caller capture the final product
  // on the same edge as the last step, saving a cycle of latency.
  always_comb begin
    product_nxt = acc + (mplier[0] ? mcand : '0);
  end

  assign done = busy && en && (count == LAST);

  // Multiplicand shifts left and multiplier shifts right each step, so bit 0
  // of mplier always selects whether the current weight gets added.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else if (en) begin
      if (start && !busy) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        count  <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= product_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        if (count == LAST) begin
          busy <= 1'b0;
        end
      end
    end
  end

endmodule : seq_multiplier

// File: rtl/alu_core_seq.sv
// ---------------------------------------------------------------------------
// alu_core_seq
//   Registered ALU between the register-file read ports and write-back.
//   Eight operations (NAND, AND, OR, XOR, ADD, SUB, NOT Rd1, MUL) with
//   valid/ready handshakes on both sides. Single-cycle ops stream back to
//   back; MUL takes WIDTH extra enabled cycles in seq_multiplier.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   en                   global enable / stall (0 freezes everything)
//   in_valid, in_ready   operand handshake (in_ready comb from out_ready)
//   op, Rd1, Rd2         operation and operands, captured on accept
//   out_valid, out_ready result handshake; result held until accepted
//   result, zero, carry  registered result and flags
// ---------------------------------------------------------------------------
module alu_core_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  Rd1,
  input  logic [WIDTH-1:0]  Rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              carry
);

  state_t state;
  state_t state_nxt;

  logic               accept;
  logic               accept_mul;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  logic               mul_start;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign accept     = in_valid && in_ready;
  assign accept_mul = accept && is_multicycle(op);
  assign mul_start  = accept_mul && !mul_busy;

  seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .start       (mul_start),
    .a           (Rd1),
    .b           (Rd2),
    .busy        (mul_busy),
    .done        (mul_done),
    .product_nxt (mul_prod)
  );

  // Single-cycle datapath. ADD and SUB use one extra bit so the top bit is
  // the carry-out or, for subtraction, the unsigned borrow (Rd1 < Rd2).
  always_comb begin
    sum       = {1'b0, Rd1} + {1'b0, Rd2};
    diff      = {1'b0, Rd1} - {1'b0, Rd2};
    alu_res   = '0;
    alu_carry = 1'b0;
    unique case (op)
      OP_NAND: alu_res = ~(Rd1 & Rd2);
      OP_AND:  alu_res = Rd1 & Rd2;
      OP_OR:   alu_res = Rd1 | Rd2;
      OP_XOR:  alu_res = Rd1 ^ Rd2;
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_carry = diff[WIDTH];
      end
      OP_NOT:  alu_res = ~Rd1;
      default: alu_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. accept already contains en, and mul_done contains en,
  // so a stalled cycle naturally leaves the state unchanged. Completing a
  // transfer in DONE while accepting new work goes straight to the new op.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = accept_mul ? ST_MUL_BUSY : ST_DONE;
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (en && out_ready) begin
          if (accept) begin
            state_nxt = accept_mul ? ST_MUL_BUSY : ST_DONE;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. in_ready looks through to out_ready so a held result can
  // be drained and replaced in the same cycle.
  always_comb begin
    out_valid = (state == ST_DONE);
    in_ready  = en && ((state == ST_IDLE) ||
                       ((state == ST_DONE) && out_ready));
  end

  // Result and flag registers. They only load on a single-cycle accept or on
  // the final multiply step, so they hold while the result waits downstream
  // and keep the previous value during a multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else if (accept && !accept_mul) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
      carry  <= alu_carry;
    end else if (mul_done) begin
      result <= mul_prod[WIDTH-1:0];
      zero   <= (mul_prod[WIDTH-1:0] == '0);
      carry  <= |mul_prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule : alu_core_seq
